// File: rtl/hex_pkg.sv
// hex_pkg: shared segment types, blank pattern and scheduler state encoding.
package hex_pkg;
  localparam logic [6:0] HEX_BLANK = 7'b1111111;
  typedef logic [6:0] seg_t;
  typedef enum logic [1:0] {IDLE, FLASH, GAP} sched_state_t;
endpackage

// File: rtl/hex_flash_arb.sv
// hex_flash_arb: combinational winner select; HEX_FLASH_SCHED_RR_EN selects round-robin, else lowest index wins.
module hex_flash_arb
  import hex_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
`ifdef HEX_FLASH_SCHED_RR_EN
  input  logic [IW-1:0]   last_idx,
`endif
  output logic [IW-1:0]   win_idx,
  output logic [NREQ-1:0] win_oh,
  output logic            valid
);
  always_comb begin
    win_idx = '0;
`ifdef HEX_FLASH_SCHED_RR_EN
    for (int k = NREQ; k >= 1; k--)
      if (req[(int'(last_idx) + k) % NREQ]) win_idx = IW'((int'(last_idx) + k) % NREQ);
`else
    for (int i = NREQ - 1; i >= 0; i--)
      if (req[i]) win_idx = IW'(i);
`endif
  end
  assign valid  = |req;
  assign win_oh = valid ? NREQ'(1) << win_idx : '0;
endmodule

// File: rtl/hex_flash_sched.sv
// hex_flash_sched: grants one requester at a time and blinks its pattern on one HEX digit.
// HEX_FLASH_SCHED_RR_EN enables the round-robin last-grant pointer.
module hex_flash_sched
  import hex_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int RATE    = 16,
  parameter int FLASHES = 12,
  parameter int GAP_CYC = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req,
  input  logic [7*NREQ-1:0] pattern_in,
  input  logic [6:0]        HEX_idle,
  input  logic              abort,
  output logic [6:0]        HEXout,
  output logic [NREQ-1:0]   grant,
  output logic              busy,
  output logic              done
);
  localparam int IW = $clog2(NREQ);
  localparam int PW = $clog2(RATE);
  localparam int FW = $clog2(FLASHES + 1);
  localparam int GW = $clog2(GAP_CYC + 1);
  sched_state_t    state_q, state_d;
  seg_t            pat_q, pat_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [PW-1:0]   phase_q, phase_d;
  logic [FW-1:0]   flash_q, flash_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic            lit_q, lit_d;
  logic            done_q, done_d;
  logic [IW-1:0]   win_idx;
  logic [NREQ-1:0] win_oh;
  logic            win_valid;
  logic            phase_wrap;
`ifdef HEX_FLASH_SCHED_RR_EN
  logic [IW-1:0]   last_q, last_d;
`endif
  hex_flash_arb #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req      (req),
`ifdef HEX_FLASH_SCHED_RR_EN
    .last_idx (last_q),
`endif
    .win_idx  (win_idx),
    .win_oh   (win_oh),
    .valid    (win_valid)
  );
  assign phase_wrap = phase_q == PW'(RATE - 1);
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    grant_d = grant_q;
    phase_d = phase_q;
    flash_d = flash_q;
    gap_d   = gap_q;
    lit_d   = lit_q;
    done_d  = 1'b0;
`ifdef HEX_FLASH_SCHED_RR_EN
    last_d  = last_q;
`endif
    case (state_q)
      IDLE: if (win_valid) begin
        state_d = FLASH;
        pat_d   = pattern_in[7*int'(win_idx) +: 7];
        grant_d = win_oh;
        phase_d = '0;
        flash_d = '0;
        lit_d   = 1'b0;
`ifdef HEX_FLASH_SCHED_RR_EN
        last_d  = win_idx;
`endif
      end
      FLASH: begin
        phase_d = phase_wrap ? '0 : phase_q + 1'b1;
        if (phase_wrap) begin
          lit_d = !lit_q;
          if (lit_q) begin
            flash_d = flash_q + 1'b1;
            if (flash_q == FW'(FLASHES - 1)) begin
              state_d = GAP;
              done_d  = 1'b1;
              grant_d = '0;
              gap_d   = '0;
            end
          end
        end
      end
      default: begin
        gap_d   = gap_q + 1'b1;
        state_d = gap_q == GW'(GAP_CYC - 1) ? IDLE : GAP;
      end
    endcase
    // abort beats a coincident terminal count, so done is suppressed too
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      grant_d = '0;
      done_d  = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      pat_q   <= HEX_BLANK;
      grant_q <= '0;
      phase_q <= '0;
      flash_q <= '0;
      gap_q   <= '0;
      lit_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      grant_q <= grant_d;
      phase_q <= phase_d;
      flash_q <= flash_d;
      gap_q   <= gap_d;
      lit_q   <= lit_d;
      done_q  <= done_d;
    end
`ifdef HEX_FLASH_SCHED_RR_EN
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) last_q <= IW'(NREQ - 1);
    else          last_q <= last_d;
`endif
  assign HEXout = state_q == IDLE  ? HEX_idle :
                  state_q == FLASH ? (lit_q ? pat_q : HEX_BLANK) : pat_q;
  assign grant  = grant_q;
  assign busy   = state_q != IDLE;
  assign done   = done_q;
endmodule

// File: tb/tb_hex_flash_sched.sv
// tb_hex_flash_sched: directed and random stimulus checked against an elapsed-time model of the flash sequence.
module tb_hex_flash_sched;
  localparam int N  = 4;
  localparam int R  = 4;
  localparam int F  = 3;
  localparam int G  = 2;
  localparam int FL = 2 * R * F;
  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           abort = 1'b0;
  logic [N-1:0]   req = '0;
  logic [7*N-1:0] pattern_in;
  logic [6:0]     HEX_idle;
  logic [6:0]     HEXout;
  logic [N-1:0]   grant;
  logic           busy;
  logic           done;
  int             total = 0;
  int             bad = 0;
  bit             m_busy;
  int             m_e;
  int             m_w;
  int             m_last;
  logic [6:0]     m_pat;
  always #5 clk = ~clk;
  hex_flash_sched #(.NREQ(N), .RATE(R), .FLASHES(F), .GAP_CYC(G)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        (req),
    .pattern_in (pattern_in),
    .HEX_idle   (HEX_idle),
    .abort      (abort),
    .HEXout     (HEXout),
    .grant      (grant),
    .busy       (busy),
    .done       (done)
  );
  function automatic int pick(input logic [N-1:0] r, input int last);
`ifdef HEX_FLASH_SCHED_RR_EN
    for (int k = 1; k <= N; k++)
      if (r[(last + k) % N]) return (last + k) % N;
`else
    for (int i = 0; i < N; i++)
      if (r[i]) return i;
`endif
    return 0;
  endfunction
  task automatic model_edge();
    if (!m_busy) begin
      if (req != '0) begin
        m_w    = pick(req, m_last);
        m_last = m_w;
        m_pat  = pattern_in[7*m_w +: 7];
        m_busy = 1'b1;
        m_e    = 0;
      end
    end else if (abort) m_busy = 1'b0;
    else begin
      m_e++;
      if (m_e == FL + G) m_busy = 1'b0;
    end
  endtask
  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask
  task automatic check_all();
    logic [6:0]   eh;
    logic [N-1:0] eg;
    logic         eb;
    logic         ed;
    eh = HEX_idle; eg = '0; eb = 1'b0; ed = 1'b0;
    if (m_busy && m_e < FL) begin
      eh = ((m_e / R) % 2 == 0) ? 7'h7f : m_pat;
      eg = N'(1) << m_w;
      eb = 1'b1;
    end else if (m_busy) begin
      eh = m_pat;
      eb = 1'b1;
      ed = (m_e == FL);
    end
    chk("hexout", HEXout, eh);
    chk("grant", 7'(grant), 7'(eg));
    chk("busy", 7'(busy), 7'(eb));
    chk("done", 7'(done), 7'(ed));
  endtask
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  initial begin
    HEX_idle   = 7'h40;
    pattern_in = {7'h11, 7'h24, 7'h79, 7'h12};
    m_busy     = 1'b0;
    m_last     = N - 1;
    #3 check_all();
    #9 reset_n = 1'b1;
    ticks(10);
    req = 4'b0100; tick(); req = '0; ticks(30);
    req = 4'b1010; ticks(60); req = '0; ticks(30);
    req = 4'b0001; tick(); req = '0; ticks(9);
    abort = 1'b1; tick(); abort = 1'b0; ticks(4);
    req = 4'b1000; tick(); req = '0; ticks(23);
    abort = 1'b1; tick(); abort = 1'b0; ticks(4);
    abort = 1'b1; ticks(3); abort = 1'b0;
    req = 4'b0010; ticks(5);
    #3 reset_n = 1'b0;
    m_busy = 1'b0;
    m_last = N - 1;
    #1 check_all();
    #2 reset_n = 1'b1;
    tick(); req = '0; ticks(30);
    for (int i = 0; i < 400; i++) begin
      req        = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      abort      = ($urandom_range(0, 19) == 0);
      HEX_idle   = 7'($urandom);
      pattern_in = (7*N)'($urandom);
      tick();
    end
    req = '0; abort = 1'b0;
    ticks(30);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
